// File: rtl/path_mux_n_if.sv
// ---------------------------------------------------------------------------
// path_mux_n_if
//   Bundles the master-side stream inputs, the slave-side req/gnt/data bus
//   and the FIFO status outputs of path_mux_n.
//   slave modport  : view taken by path_mux_n itself
//   master modport : view taken by whatever drives the masters and slaves
//
//   valid_i  [NUM_MASTERS]           per-master valid
//   stop_o   [NUM_MASTERS]           per-master back-pressure
//   id_i     [NUM_MASTERS*IDWIDTH]   per-master slave ID, master k at slice k
//   data_i   [NUM_MASTERS*DWIDTH]    per-master payload
//   req_o    [NUM_SLAVES]            request to slave s
//   gnt_i    [NUM_SLAVES]            grant from slave s
//   valid_o  [NUM_SLAVES]            data valid to slave s
//   data_o   [NUM_SLAVES*DWIDTH]     payload to slave s
//   empty_o, full_o, count_o         FIFO occupancy
//   overflow_o, underflow_o          registered protocol-error pulses
// ---------------------------------------------------------------------------
interface path_mux_n_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int IDWIDTH     = 1,
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 4
);
    logic [NUM_MASTERS-1:0]         valid_i;
    logic [NUM_MASTERS-1:0]         stop_o;
    logic [NUM_MASTERS*IDWIDTH-1:0] id_i;
    logic [NUM_MASTERS*DWIDTH-1:0]  data_i;
    logic [NUM_SLAVES-1:0]          req_o;
    logic [NUM_SLAVES-1:0]          gnt_i;
    logic [NUM_SLAVES-1:0]          valid_o;
    logic [NUM_SLAVES*DWIDTH-1:0]   data_o;
    logic                           empty_o;
    logic                           full_o;
    logic [$clog2(DEPTH):0]         count_o;
    logic                           overflow_o;
    logic                           underflow_o;

    modport slave (
        input  valid_i, id_i, data_i, gnt_i,
        output stop_o, req_o, valid_o, data_o,
        output empty_o, full_o, count_o, overflow_o, underflow_o
    );

    modport master (
        output valid_i, id_i, data_i, gnt_i,
        input  stop_o, req_o, valid_o, data_o,
        input  empty_o, full_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/path_mux_n.sv
// ---------------------------------------------------------------------------
// path_mux_n
//   Round-robin time-slot arbiter from NUM_MASTERS streams into one shared
//   FIFO. Each entry carries a slave ID; the FIFO head is offered to that
//   slave over req/gnt. With BYPASS_EN, an entry arriving while the FIFO is
//   empty and already granted goes straight through in the same cycle.
//
//   clk  : clock
//   rst  : asynchronous active-high reset (control state only)
//   bus  : path_mux_n_if.slave -- stream inputs, slave bus, status/error flags
// ---------------------------------------------------------------------------
module path_mux_n #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int IDWIDTH     = 1,
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 4,
    parameter int BYPASS_EN   = 1
) (
    input  logic          clk,
    input  logic          rst,
    path_mux_n_if.slave   bus
);
    localparam int PW = $clog2(NUM_MASTERS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0]                rr_ptr;
    logic [CW-1:0]                count;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         ovf_q;
    logic                         unf_q;
    logic [IDWIDTH-1:0]           mem_id   [DEPTH];
    logic [DWIDTH-1:0]            mem_data [DEPTH];

    logic                         empty;
    logic                         full;
    logic [NUM_MASTERS-1:0]       stop;
    logic                         in_vld;
    logic [IDWIDTH-1:0]           in_id;
    logic [DWIDTH-1:0]            in_data;
    logic [IDWIDTH-1:0]           head_id;
    logic [DWIDTH-1:0]            head_data;
    logic [NUM_SLAVES-1:0]        in_hit;
    logic [NUM_SLAVES-1:0]        head_hit;
    logic [NUM_SLAVES-1:0]        req;
    logic [NUM_SLAVES-1:0]        vout;
    logic [NUM_SLAVES*DWIDTH-1:0] dout;
    logic                         id_ok;
    logic                         gnt_err;
    logic                         pop;
    logic                         bypass;
    logic                         push;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_id   = mem_id[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // ---- slot selection: only the master owning the current slot may enter
    always_comb begin : slot_sel
        stop    = '1;
        in_vld  = 1'b0;
        in_id   = '0;
        in_data = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!rst && !full && rr_ptr == PW'(k)) begin
                stop[k] = 1'b0;
                in_vld  = bus.valid_i[k];
                in_id   = bus.id_i[k*IDWIDTH +: IDWIDTH];
                in_data = bus.data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // ---- routing: request, grant checking, pop / bypass / push decisions
    always_comb begin : route
        in_hit   = '0;
        head_hit = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            in_hit[s]   = (in_id == IDWIDTH'(s));
            head_hit[s] = (head_id == IDWIDTH'(s));
        end
        // An ID that decodes to no slave is an error and never enters the FIFO
        id_ok = |in_hit;
        req   = ({NUM_SLAVES{!empty}} & head_hit) |
                ({NUM_SLAVES{(BYPASS_EN != 0) && empty && in_vld}} & in_hit);
        // Illegal grants (unrequested or multi-hot) leave the FIFO untouched
        gnt_err = (|(bus.gnt_i & ~req)) ||
                  ((bus.gnt_i & (bus.gnt_i - NUM_SLAVES'(1))) != '0);
        pop     = !empty && (|(bus.gnt_i & head_hit)) && !gnt_err;
        bypass  = (BYPASS_EN != 0) && empty && in_vld && id_ok &&
                  (|(bus.gnt_i & in_hit)) && !gnt_err;
        push    = in_vld && id_ok && !bypass;

        vout = pop ? head_hit : (bypass ? in_hit : '0);
        dout = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (vout[s]) begin
                dout[s*DWIDTH +: DWIDTH] = pop ? head_data : in_data;
            end
        end
    end

    // ---- control registers: slot pointer, FIFO pointers, error pulses
    always_ff @(posedge clk or posedge rst) begin : ctrl
        if (rst) begin
            rr_ptr <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            // Slots rotate unconditionally; an unused slot is simply lost
            rr_ptr <= (rr_ptr == PW'(NUM_MASTERS-1)) ? '0 : rr_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            ovf_q <= |(bus.valid_i & stop);
            unf_q <= gnt_err || (in_vld && !id_ok);
        end
    end

    // ---- FIFO storage: data path, not reset
    always_ff @(posedge clk) begin : store
        if (push) begin
            mem_id[wr_ptr]   <= in_id;
            mem_data[wr_ptr] <= in_data;
        end
    end

    assign bus.stop_o      = stop;
    assign bus.req_o       = req;
    assign bus.valid_o     = vout;
    assign bus.data_o      = dout;
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.count_o     = count;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_path_mux_n.sv
// ---------------------------------------------------------------------------
// tb_path_mux_n
//   Directed bench for path_mux_n. Two instances share clock and reset:
//   u_byp (BYPASS_EN=1) carries most of the sequence, u_nob (BYPASS_EN=0)
//   covers the non-bypass path. Expected slave/data pairs for u_byp are
//   queued when stimulus is driven and consumed as valid_o appears.
// ---------------------------------------------------------------------------
module tb_path_mux_n;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    path_mux_n_if #(.NUM_MASTERS(2), .NUM_SLAVES(2), .IDWIDTH(1), .DWIDTH(8), .DEPTH(4)) bif ();
    path_mux_n_if #(.NUM_MASTERS(2), .NUM_SLAVES(2), .IDWIDTH(1), .DWIDTH(8), .DEPTH(4)) nif ();

    path_mux_n #(.NUM_MASTERS(2), .NUM_SLAVES(2), .IDWIDTH(1), .DWIDTH(8), .DEPTH(4),
                 .BYPASS_EN(1)) u_byp (.clk(clk), .rst(rst), .bus(bif.slave));
    path_mux_n #(.NUM_MASTERS(2), .NUM_SLAVES(2), .IDWIDTH(1), .DWIDTH(8), .DEPTH(4),
                 .BYPASS_EN(0)) u_nob (.clk(clk), .rst(rst), .bus(nif.slave));

    typedef struct {
        int         slv;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   rr_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_sample();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (bif.valid_o[s]) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_slave", s, e.slv);
                    chk("sb_data", bif.data_o[s*8 +: 8], e.d);
                end
            end else begin
                chk("sb_idle_zero", bif.data_o[s*8 +: 8], 0);
            end
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge
    task automatic tick();
        #1;
        sb_sample();
        @(posedge clk);
        if (!rst) rr_m = (rr_m + 1) % 2;
        @(negedge clk);
    endtask

    task automatic idle();
        bif.valid_i = '0;
        bif.gnt_i   = '0;
        nif.valid_i = '0;
        nif.gnt_i   = '0;
    endtask

    task automatic send(input int k, input logic id, input logic [7:0] d);
        bif.valid_i            = '0;
        bif.valid_i[k]         = 1'b1;
        bif.id_i[k]            = id;
        bif.data_i[k*8 +: 8]   = d;
        exp_q.push_back('{slv: int'(id), d: d});
    endtask

    // Acts as the slaves: grant whatever is requested until the FIFO empties
    task automatic drain();
        for (int i = 0; i < 20 && bif.count_o != 0; i++) begin
            idle();
            #1;
            if (exp_q.size() > 0) chk("req_head", bif.req_o, 1 << exp_q[0].slv);
            bif.gnt_i = bif.req_o;
            tick();
        end
        chk("drained", bif.count_o, 0);
    endtask

    task automatic wait_slot(input int k);
        for (int i = 0; i < 4 && rr_m != k; i++) begin
            idle();
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bif.id_i = '0; bif.data_i = '0;
        nif.id_i = '0; nif.data_i = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_count", bif.count_o, 0);
        chk("rst_empty", bif.empty_o, 1);
        chk("rst_full", bif.full_o, 0);
        chk("rst_stop", bif.stop_o, 2'b11);
        chk("rst_ovf", bif.overflow_o, 0);
        chk("rst_unf", bif.underflow_o, 0);
        chk("rst_req", bif.req_o, 0);
        chk("rst_valid", bif.valid_o, 0);
        chk("rst_nob_stop", nif.stop_o, 2'b11);

        rst  = 1'b0;
        rr_m = 0;
        tick();
        tick();

        // Bypass on u_byp; plain push then grant on u_nob
        send(0, 1'b1, 8'hA5);
        bif.gnt_i       = 2'b10;
        nif.valid_i     = 2'b01;
        nif.id_i[0]     = 1'b1;
        nif.data_i[7:0] = 8'hA5;
        nif.gnt_i       = 2'b00;
        #1;
        chk("byp_req", bif.req_o, 2'b10);
        chk("byp_valid", bif.valid_o, 2'b10);
        chk("nob_req_none", nif.req_o, 0);
        tick();
        chk("byp_count", bif.count_o, 0);
        chk("byp_empty", bif.empty_o, 1);
        chk("nob_count", nif.count_o, 1);
        idle();
        #1;
        chk("nob_req_next", nif.req_o, 2'b10);
        nif.gnt_i = 2'b10;
        #1;
        chk("nob_valid", nif.valid_o, 2'b10);
        chk("nob_data", nif.data_o[15:8], 8'hA5);
        tick();
        chk("nob_count_after", nif.count_o, 0);
        chk("nob_unf", nif.underflow_o, 0);
        chk("byp_unf", bif.underflow_o, 0);
        idle();

        // Fill to DEPTH without grants, then release one entry
        for (int i = 0; i < 4; i++) begin
            send(rr_m, 1'(i), 8'h40 + 8'(i));
            tick();
        end
        idle();
        chk("full_flag", bif.full_o, 1);
        chk("full_count", bif.count_o, 4);
        chk("full_stop", bif.stop_o, 2'b11);
        chk("full_empty", bif.empty_o, 0);
        #1;
        chk("full_req", bif.req_o, 2'b01);
        bif.gnt_i = 2'b01;
        tick();
        chk("unfull_flag", bif.full_o, 0);
        chk("unfull_count", bif.count_o, 3);
        drain();

        // Strict FIFO order across slaves
        send(rr_m, 1'b0, 8'h11); tick();
        send(rr_m, 1'b1, 8'h22); tick();
        send(rr_m, 1'b0, 8'h33); tick();
        idle();
        chk("order_count", bif.count_o, 3);
        drain();

        // Off-slot valid -> overflow, data dropped
        wait_slot(0);
        bif.valid_i      = 2'b10;
        bif.id_i[1]      = 1'b0;
        bif.data_i[15:8] = 8'hEE;
        tick();
        chk("ovf_pulse", bif.overflow_o, 1);
        chk("ovf_count", bif.count_o, 0);
        idle();
        tick();
        chk("ovf_clear", bif.overflow_o, 0);

        // Unrequested grant -> underflow
        bif.gnt_i = 2'b01;
        #1;
        chk("unf_req", bif.req_o, 0);
        tick();
        chk("unf_pulse", bif.underflow_o, 1);
        chk("unf_count", bif.count_o, 0);
        idle();
        tick();
        chk("unf_clear", bif.underflow_o, 0);

        // Reset mid-operation
        send(rr_m, 1'b0, 8'h51); tick();
        send(rr_m, 1'b1, 8'h52); tick();
        send(rr_m, 1'b0, 8'h53); tick();
        idle();
        chk("pre_rst_count", bif.count_o, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", bif.count_o, 0);
        chk("mid_rst_empty", bif.empty_o, 1);
        chk("mid_rst_stop", bif.stop_o, 2'b11);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        rr_m = 0;
        bif.valid_i = 2'b11;
        bif.id_i    = 2'b00;
        bif.data_i  = {8'h88, 8'h77};
        exp_q.push_back('{slv: 0, d: 8'h77});
        #1;
        chk("post_rst_stop", bif.stop_o, 2'b10);
        tick();
        chk("post_rst_count", bif.count_o, 1);
        chk("post_rst_ovf", bif.overflow_o, 1);
        idle();
        drain();

        chk("sb_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
